flag_ctrl: RTL
==============

FLAG_CTRL -- requirements
Module: flag_ctrl

Interface
REQ-001 Parameter FLAG_W, default 3, flag vector width; bit 0 = Z, bit 1 = N, bit 2 = C.
REQ-002 Parameter SHADOW_DEPTH, default 2, number of interrupt flag-save entries.
REQ-003 Clock and reset: reset reset, synchronous, active-high; clock clk.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 alu_valid  in  1  execute stage presents a flag update this cycle.
REQ-007 alu_mask  in  FLAG_W  per-flag write enable for the ALU update.
REQ-008 alu_flags  in  FLAG_W  ALU-computed flag values.
REQ-009 setc / clrc  in  1 each  set-carry / clear-carry instruction in execute.
REQ-010 int_req  in  1  interrupt entry request; level, held until int_ack.
REQ-011 int_ack  out  1  one-cycle pulse when flags are saved and cleared.
REQ-012 rti_req  in  1  return-from-interrupt restore request; level, held until rti_ack.
REQ-013 rti_ack  out  1  one-cycle pulse when flags are restored.
REQ-014 fr_rdata  in  FLAG_W  current flag register contents.
REQ-015 fr_we / fr_wdata  out  1 / FLAG_W  flag register write port; the register captures on the falling edge of the same cycle.
REQ-016 flags_fwd  out  FLAG_W  flag value valid after this cycle: fr_we ? fr_wdata : fr_rdata.
REQ-017 busy  out  1  pipeline stall: (state != IDLE) | int_req | rti_req.
REQ-018 shadow_depth  out  2  number of occupied shadow entries.
REQ-019 ovf_err / unf_err  out  1 each  sticky shadow overflow / underflow flags.

Function
REQ-020 FSM states: IDLE, SAVE, CLEAR, RESTORE.
REQ-021 IDLE, ALU/carry path:
- fr_wdata = ((fr_rdata & ~alu_mask) | (alu_flags & alu_mask)) when alu_valid, else fr_rdata.
- setc then forces C=1; clrc forces C=0; setc wins if both are asserted.
- fr_we = (alu_valid & |alu_mask) | setc | clrc.
REQ-022 IDLE transitions:
- int_req=1 -> SAVE.
- else rti_req=1 -> RESTORE.
- int_req wins when both are asserted.
- The IDLE-cycle ALU/carry write still occurs in the transition cycle.
REQ-023 SAVE:
- push fr_rdata (includes the prior falling-edge write) onto the shadow stack.
- fr_we=0; next state CLEAR.
REQ-024 CLEAR: fr_we=1, fr_wdata=0, int_ack=1; next state IDLE.
REQ-025 RESTORE:
- fr_we=1, fr_wdata=top entry; pop.
- rti_ack=1; next state IDLE.
REQ-026 Outside IDLE, alu_valid/setc/clrc are ignored.
REQ-027 Push when shadow_depth==SHADOW_DEPTH: no push, ovf_err set; SAVE/CLEAR sequence completes normally.
REQ-028 Pop when shadow_depth==0: fr_we=0 (flags unchanged), unf_err set, rti_ack still pulses.
REQ-029 int_ack and rti_ack are never asserted in the same cycle.
REQ-030 A request still high in the cycle after its ack starts a new sequence; requesters drop req on the ack cycle.

Reset
REQ-031 reset=1:
- state IDLE, shadow_depth 0, all shadow entries 0.
- ovf_err=0, unf_err=0.
- fr_we=0, int_ack=0, rti_ack=0 during and after the reset cycle.
REQ-032 Reset mid-sequence (SAVE/CLEAR/RESTORE) aborts without ack; the flag register resets itself independently.
REQ-033 ovf_err/unf_err clear only on reset.

Structure
REQ-034 Package flag_pkg holds:
- FLAG_W and the Z/N/C bit indices.
- the FSM state enum.
- the SHADOW_DEPTH default.
REQ-035 Shadow storage is sub-module flag_shadow_stack:
- ports: push, pop, push_data, top_data, depth, full, empty.
- flag_ctrl holds the FSM and the write-merge logic.

Verification
REQ-036 fr_rdata=3'b000, alu_valid=1, alu_mask=3'b011, alu_flags=3'b111 -> fr_we=1, fr_wdata=3'b011, flags_fwd=3'b011.
REQ-037 fr_rdata=3'b011, setc=1 and clrc=1 together -> fr_wdata=3'b111.
REQ-038 Interrupt entry with fr_rdata=3'b101, int_req held:
- SAVE next cycle with shadow_depth->1.
- CLEAR cycle with fr_wdata=0 and int_ack=1.
- busy high throughout.
REQ-039 Nested interrupts: interrupts with flags 3'b001 then 3'b110, a third interrupt, then three RTIs ->
- ovf_err=1 on the third entry.
- restores 3'b110, then 3'b001.
- third RTI: unf_err=1, fr_we=0, rti_ack pulses.
REQ-040 int_req and rti_req rise in the same cycle -> SAVE taken first; RESTORE after int_ack, once int_req is low.
REQ-041 reset asserted in SAVE -> next cycle: IDLE, shadow_depth=0, no int_ack, error flags 0.

Source files
------------

// File: rtl/flag_pkg.sv
// Shared definitions for the flag controller: flag layout, FSM states and
// the default depth of the interrupt flag-save stack.
package flag_pkg;

  // Flag vector layout
  localparam int FLAG_W = 3;
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;

  // Default number of interrupt flag-save entries
  localparam int SHADOW_DEPTH = 2;

  // Controller sequencing states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAVE    = 2'd1,
    CLEAR   = 2'd2,
    RESTORE = 2'd3
  } state_e;

  // Number of bits needed to count 0..depth occupied entries
  function automatic int depth_bits(input int depth);
    return (depth < 2) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/flag_shadow_stack.sv
// LIFO holding flag snapshots taken on interrupt entry. Pushes into a full
// stack and pops from an empty stack are ignored here; the controller turns
// them into sticky error flags.
module flag_shadow_stack
  import flag_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int DEPTH   = 2,
  parameter int DEPTH_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic [WIDTH-1:0]   push_data,
  output logic [WIDTH-1:0]   top_data,
  output logic [DEPTH_W-1:0] depth,
  output logic               full,
  output logic               empty
);

  logic [WIDTH-1:0]   entries_r [DEPTH];
  logic [DEPTH_W-1:0] depth_r;
  logic [WIDTH-1:0]   top_data_s;

  // Entry storage and occupancy counter; reset clears every entry
  always_ff @(posedge clk) begin
    if (reset) begin
      depth_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries_r[i] <= '0;
      end
    end else if (push && !full) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (depth_r == DEPTH_W'(i)) begin
          entries_r[i] <= push_data;
        end
      end
      depth_r <= depth_r + DEPTH_W'(1);
    end else if (pop && !empty) begin
      depth_r <= depth_r - DEPTH_W'(1);
    end
  end

  // Select the most recently pushed entry (zero when empty)
  always_comb begin
    top_data_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      top_data_s = top_data_s | ({WIDTH{depth_r == DEPTH_W'(i + 1)}} & entries_r[i]);
    end
  end

  assign top_data = top_data_s;
  assign depth    = depth_r;
  assign full     = (depth_r == DEPTH_W'(DEPTH));
  assign empty    = (depth_r == DEPTH_W'(0));

endmodule

// File: rtl/flag_ctrl.sv
// Flag register controller: merges ALU and carry-instruction updates into the
// flag register write port, and sequences interrupt save/clear and
// return-from-interrupt restore through a small shadow stack.
module flag_ctrl #(
  parameter int FLAG_W       = flag_pkg::FLAG_W,
  parameter int SHADOW_DEPTH = flag_pkg::SHADOW_DEPTH,
  parameter int DEPTH_W      = flag_pkg::depth_bits(flag_pkg::SHADOW_DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               alu_valid,
  input  logic [FLAG_W-1:0]  alu_mask,
  input  logic [FLAG_W-1:0]  alu_flags,
  input  logic               setc,
  input  logic               clrc,
  input  logic               int_req,
  output logic               int_ack,
  input  logic               rti_req,
  output logic               rti_ack,
  input  logic [FLAG_W-1:0]  fr_rdata,
  output logic               fr_we,
  output logic [FLAG_W-1:0]  fr_wdata,
  output logic [FLAG_W-1:0]  flags_fwd,
  output logic               busy,
  output logic [DEPTH_W-1:0] shadow_depth,
  output logic               ovf_err,
  output logic               unf_err
);

  import flag_pkg::*;

  state_e             state_r;
  logic               int_ack_r;
  logic               rti_ack_r;
  logic               ovf_err_r;
  logic               unf_err_r;

  logic [FLAG_W-1:0]  base_s;
  logic               carry_s;
  logic [FLAG_W-1:0]  merged_s;
  logic               alu_we_s;
  logic               we_s;
  logic [FLAG_W-1:0]  wdata_s;
  logic               push_s;
  logic               pop_s;
  logic [FLAG_W-1:0]  top_s;
  logic               full_s;
  logic               empty_s;
  logic [DEPTH_W-1:0] depth_s;

  flag_shadow_stack #(
    .WIDTH   (FLAG_W),
    .DEPTH   (SHADOW_DEPTH),
    .DEPTH_W (DEPTH_W)
  ) u_shadow (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (fr_rdata),
    .top_data  (top_s),
    .depth     (depth_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  // ALU masked merge followed by the carry instructions (setc dominates clrc)
  always_comb begin
    base_s = alu_valid ? ((fr_rdata & ~alu_mask) | (alu_flags & alu_mask)) : fr_rdata;
    if (setc) begin
      carry_s = 1'b1;
    end else if (clrc) begin
      carry_s = 1'b0;
    end else begin
      carry_s = base_s[FLAG_C];
    end
    merged_s         = base_s;
    merged_s[FLAG_C] = carry_s;
    alu_we_s         = (alu_valid & (|alu_mask)) | setc | clrc;
  end

  // Per-state drive of the flag write port and the shadow stack
  always_comb begin
    we_s    = 1'b0;
    wdata_s = fr_rdata;
    push_s  = 1'b0;
    pop_s   = 1'b0;
    case (state_r)
      IDLE: begin
        we_s    = alu_we_s;
        wdata_s = merged_s;
      end
      SAVE: begin
        push_s = ~full_s;
      end
      CLEAR: begin
        we_s    = 1'b1;
        wdata_s = '0;
      end
      RESTORE: begin
        if (!empty_s) begin
          we_s    = 1'b1;
          wdata_s = top_s;
          pop_s   = 1'b1;
        end else begin
          we_s    = 1'b0;
          wdata_s = fr_rdata;
        end
      end
      default: begin
        we_s    = 1'b0;
        wdata_s = fr_rdata;
      end
    endcase
  end

  // Sequencer with registered acknowledges and sticky stack error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      int_ack_r <= 1'b0;
      rti_ack_r <= 1'b0;
      ovf_err_r <= 1'b0;
      unf_err_r <= 1'b0;
    end else begin
      int_ack_r <= 1'b0;
      rti_ack_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (int_req) begin
            state_r <= SAVE;
          end else if (rti_req) begin
            state_r   <= RESTORE;
            rti_ack_r <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        SAVE: begin
          state_r   <= CLEAR;
          int_ack_r <= 1'b1;
          if (full_s) begin
            ovf_err_r <= 1'b1;
          end
        end
        CLEAR: begin
          state_r <= IDLE;
        end
        RESTORE: begin
          state_r <= IDLE;
          if (empty_s) begin
            unf_err_r <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Writes and acks are suppressed in the reset cycle so an aborted sequence
  // never touches the flag register or signals completion.
  assign fr_we        = we_s & ~reset;
  assign fr_wdata     = wdata_s;
  assign flags_fwd    = fr_we ? fr_wdata : fr_rdata;
  assign int_ack      = int_ack_r & ~reset;
  assign rti_ack      = rti_ack_r & ~reset;
  assign busy         = (state_r != IDLE) | int_req | rti_req;
  assign shadow_depth = depth_s;
  assign ovf_err      = ovf_err_r;
  assign unf_err      = unf_err_r;

endmodule
